// File: rtl/simon.sv
// Simon memory game core: stores a growing 4-bit pattern sequence, plays it back, and checks the player's repeat.
// Outputs are combinational from state, memory and switches; each pclk edge advances the game by one step.

// 64x4 sequence store; synchronous write, asynchronous read.
module simon_mem (
  input  logic       pclk,
  input  logic       i_we,
  input  logic [5:0] i_waddr,
  input  logic [3:0] i_wdat,
  input  logic [5:0] i_raddr,
  output logic [3:0] o_rdat
);
  logic [3:0] mem [0:63];

  always_ff @(posedge pclk) begin
    if (i_we) mem[i_waddr] <= i_wdat;
  end

  assign o_rdat = mem[i_raddr];
endmodule

// Datapath: sequence memory plus the LED source select (stored step or live switches).
module simon_dpath (
  input  logic       pclk,
  input  logic       i_we,
  input  logic [5:0] i_waddr,
  input  logic [5:0] i_raddr,
  input  logic [3:0] i_pattern,
  input  logic       i_show_mem,
  output logic [3:0] o_rd,
  output logic [3:0] o_leds
);
  logic [3:0] w_rd;

  simon_mem mem (
    .pclk    (pclk),
    .i_we    (i_we),
    .i_waddr (i_waddr),
    .i_wdat  (i_pattern),
    .i_raddr (i_raddr),
    .o_rdat  (w_rd)
  );

  assign o_rd   = w_rd;
  assign o_leds = i_show_mem ? w_rd : i_pattern;
endmodule

// Game controller: INPUT -> PLAYBACK -> REPEAT -> (INPUT | DONE); DONE loops the sequence until reset.
module simon (
  input  logic       pclk,
  input  logic       rst,
  input  logic       level,
  input  logic [3:0] pattern,
  output logic [3:0] pattern_leds,
  output logic [2:0] mode_leds
);
  typedef enum logic [1:0] {INPUT = 2'd0, PLAYBACK = 2'd1, REPEAT = 2'd2, DONE = 2'd3} mode_t;

  mode_t      r_mode, w_mode_nxt;
  logic [6:0] r_len, w_len_nxt;
  logic [5:0] r_idx, w_idx_nxt;
  logic       r_lvl;
  logic       w_we, w_valid, w_last, w_show_mem;
  logic [3:0] w_rd;

  // Easy level accepts only single-bit patterns; hard accepts anything.
  always_comb begin
    w_valid = r_lvl;
    case (pattern)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: w_valid = 1'b1;
      default: ;
    endcase
  end

  assign w_last = ({1'b0, r_idx} == (r_len - 7'd1));

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_mode <= INPUT;
      r_len  <= 7'd0;
      r_idx  <= 6'd0;
      r_lvl  <= level;
    end else begin
      r_mode <= w_mode_nxt;
      r_len  <= w_len_nxt;
      r_idx  <= w_idx_nxt;
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    w_len_nxt  = r_len;
    w_idx_nxt  = r_idx;
    w_we       = 1'b0;
    w_show_mem = 1'b0;
    mode_leds  = 3'b001;
    case (r_mode)
      INPUT: begin
        if (w_valid) begin
          w_we       = 1'b1;
          w_len_nxt  = r_len + 7'd1;
          w_idx_nxt  = 6'd0;
          w_mode_nxt = PLAYBACK;
        end
      end
      PLAYBACK: begin
        mode_leds  = 3'b010;
        w_show_mem = 1'b1;
        if (w_last) begin
          w_idx_nxt  = 6'd0;
          w_mode_nxt = REPEAT;
        end else begin
          w_idx_nxt = r_idx + 6'd1;
        end
      end
      REPEAT: begin
        mode_leds = 3'b100;
        if (pattern != w_rd) begin
          w_idx_nxt  = 6'd0;
          w_mode_nxt = DONE;
        end else if (w_last) begin
          w_idx_nxt  = 6'd0;
          w_mode_nxt = (r_len == 7'd64) ? DONE : INPUT;
        end else begin
          w_idx_nxt = r_idx + 6'd1;
        end
      end
      DONE: begin
        mode_leds  = 3'b111;
        w_show_mem = 1'b1;
        w_idx_nxt  = w_last ? 6'd0 : r_idx + 6'd1;
      end
      default: ;
    endcase
  end

  // INPUT is never entered with len==64, so len[5:0] is always an in-range write address.
  simon_dpath dpath (
    .pclk       (pclk),
    .i_we       (w_we),
    .i_waddr    (r_len[5:0]),
    .i_raddr    (r_idx),
    .i_pattern  (pattern),
    .i_show_mem (w_show_mem),
    .o_rd       (w_rd),
    .o_leds     (pattern_leds)
  );
endmodule

// File: tb/tb_simon.sv
// Self-checking bench for simon: directed vector table followed by randomized games against a sequence-level model.
module tb_simon;
  logic       pclk = 1'b0;
  logic       rst = 1'b0;
  logic       level = 1'b0;
  logic [3:0] pattern = 4'b0000;
  logic [3:0] pattern_leds;
  logic [2:0] mode_leds;

  int n_checks = 0;
  int n_fail = 0;

  simon dut (
    .pclk         (pclk),
    .rst          (rst),
    .level        (level),
    .pattern      (pattern),
    .pattern_leds (pattern_leds),
    .mode_leds    (mode_leds)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic       rst;
    logic       lvl;
    logic [3:0] pat;
    logic       clk;
    logic [2:0] mode;
    logic [3:0] leds;
  } vec_t;

  vec_t vecs[18];

  // Model: game phase (held as the expected mode LED value), stored sequence, cursor, latched level.
  localparam int MI = 1, MP = 2, MR = 4, MD = 7;
  int         m_mode;
  logic [3:0] m_seq[$];
  int         m_pos;
  logic       m_lvl;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_leds(input logic [3:0] p);
    if (m_mode == MI || m_mode == MR) return p;
    return m_seq[m_pos];
  endfunction

  function automatic bit model_valid(input logic [3:0] p);
    return m_lvl || ($countones(p) == 1);
  endfunction

  task automatic model_clock(input logic [3:0] p);
    case (m_mode)
      MI: if (model_valid(p)) begin
            m_seq.push_back(p);
            m_pos  = 0;
            m_mode = MP;
          end
      MP: if (m_pos == m_seq.size() - 1) begin
            m_pos  = 0;
            m_mode = MR;
          end else m_pos++;
      MR: if (p != m_seq[m_pos]) begin
            m_pos  = 0;
            m_mode = MD;
          end else if (m_pos == m_seq.size() - 1) begin
            m_pos  = 0;
            m_mode = (m_seq.size() == 64) ? MD : MI;
          end else m_pos++;
      default: m_pos = (m_pos + 1) % m_seq.size();
    endcase
  endtask

  task automatic do_reset(input logic lvl);
    rst   = 1'b0;
    level = lvl;
    @(posedge pclk);
    #1;
    rst   = 1'b1;
    level = 1'($urandom);
    m_seq.delete();
    m_pos  = 0;
    m_mode = MI;
    m_lvl  = lvl;
    #1;
    check("reset_mode", {5'd0, mode_leds}, 8'(MI));
  endtask

  // One game step: check the combinational view, clock, then check the post-edge view.
  task automatic step(input logic [3:0] p);
    pattern = p;
    #1;
    check("comb_mode", {5'd0, mode_leds}, 8'(m_mode));
    check("comb_leds", {4'd0, pattern_leds}, {4'd0, model_leds(p)});
    @(posedge pclk);
    model_clock(p);
    #1;
    check("edge_mode", {5'd0, mode_leds}, 8'(m_mode));
    check("edge_leds", {4'd0, pattern_leds}, {4'd0, model_leds(p)});
  endtask

  function automatic logic [3:0] pick(input bit easy_bias);
    logic [3:0] p;
    p = 4'($urandom);
    if (easy_bias && $urandom_range(0, 1) == 0) p = 4'b0001 << $urandom_range(0, 3);
    return p;
  endfunction

  initial begin
    //          rst   lvl   pat      clk   mode     leds
    vecs[0]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 3'b001, 4'b0000};
    vecs[1]  = '{1'b1, 1'b0, 4'b0001, 1'b0, 3'b001, 4'b0001};
    vecs[2]  = '{1'b1, 1'b0, 4'b0001, 1'b1, 3'b010, 4'b0001};
    vecs[3]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 3'b010, 4'b0001};
    vecs[4]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 3'b100, 4'b0000};
    vecs[5]  = '{1'b1, 1'b0, 4'b0001, 1'b0, 3'b100, 4'b0001};
    vecs[6]  = '{1'b1, 1'b0, 4'b0001, 1'b1, 3'b001, 4'b0001};
    vecs[7]  = '{1'b1, 1'b1, 4'b1010, 1'b1, 3'b001, 4'b1010};
    vecs[8]  = '{1'b1, 1'b1, 4'b1000, 1'b1, 3'b010, 4'b0001};
    vecs[9]  = '{1'b1, 1'b1, 4'b0000, 1'b1, 3'b010, 4'b1000};
    vecs[10] = '{1'b1, 1'b1, 4'b0000, 1'b1, 3'b100, 4'b0000};
    vecs[11] = '{1'b1, 1'b1, 4'b0001, 1'b1, 3'b100, 4'b0001};
    vecs[12] = '{1'b1, 1'b1, 4'b0100, 1'b1, 3'b111, 4'b0001};
    vecs[13] = '{1'b1, 1'b1, 4'b0000, 1'b1, 3'b111, 4'b1000};
    vecs[14] = '{1'b1, 1'b1, 4'b0000, 1'b1, 3'b111, 4'b0001};
    vecs[15] = '{1'b0, 1'b1, 4'b1010, 1'b0, 3'b001, 4'b1010};
    vecs[16] = '{1'b0, 1'b1, 4'b1010, 1'b1, 3'b001, 4'b1010};
    vecs[17] = '{1'b1, 1'b0, 4'b1010, 1'b1, 3'b010, 4'b1010};

    #2;
    for (int i = 0; i < 18; i++) begin
      rst     = vecs[i].rst;
      level   = vecs[i].lvl;
      pattern = vecs[i].pat;
      if (vecs[i].clk) begin
        @(posedge pclk);
        #1;
      end else begin
        #1;
      end
      check($sformatf("vec%0d_mode", i), {5'd0, mode_leds}, {5'd0, vecs[i].mode});
      check($sformatf("vec%0d_leds", i), {4'd0, pattern_leds}, {4'd0, vecs[i].leds});
    end

    // Full capacity in hard mode: every round repeated correctly until memory is full.
    do_reset(1'b1);
    for (int cyc = 0; cyc < 6000 && m_mode != MD; cyc++) begin
      if (m_mode == MR) step(m_seq[m_pos]);
      else step(4'($urandom));
    end
    check("cap_done_mode", {5'd0, mode_leds}, 8'(3'b111));
    for (int k = 0; k < 70; k++) step(4'($urandom));

    // Random games: mixed levels, invalid entries, occasional wrong guesses.
    for (int g = 0; g < 8; g++) begin
      do_reset(1'($urandom));
      for (int s = 0; s < 250; s++) begin
        if (m_mode == MR && $urandom_range(0, 19) != 0) step(m_seq[m_pos]);
        else step(pick(1'b1));
      end
    end

    // Asynchronous reset mid-game, with no clock edge.
    rst = 1'b0;
    pattern = 4'b0110;
    #1;
    check("async_rst_mode", {5'd0, mode_leds}, 8'(3'b001));
    check("async_rst_leds", {4'd0, pattern_leds}, 8'(4'b0110));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
